// File: rtl/blackbox_prober.sv
// blackbox_prober: sweeps every input vector of a small combinational box,
// captures its truth table, counts minterms and compares to a reference.
`timescale 1ns/1ps
module blackbox_prober #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected_tt,
  output logic [N_IN-1:0]      probe_out,
  input  logic                 probe_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   truth_table,
  output logic [N_IN:0]        ones_count,
  output logic                 match
);

  localparam int NV = 2**N_IN;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    FINISH
  } state_t;

  state_t          state;
  logic [N_IN-1:0] vec;
  logic [SW-1:0]   sc;
  logic [NV-1:0]   exp_tt;
  logic [NV-1:0]   tt_next;
  logic            hold_end;
  logic            last_vec;

  // Table as it will look after this cycle's capture, so match can be
  // registered on the same edge that enters FINISH.
  always_comb begin
    tt_next      = truth_table;
    tt_next[vec] = probe_in;
  end

  assign hold_end = (sc == SW'(SETTLE - 1));
  assign last_vec = (vec == N_IN'(NV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      vec         <= '0;
      sc          <= '0;
      exp_tt      <= '0;
      probe_out   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= '0;
      ones_count  <= '0;
      match       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= DRIVE;
            vec         <= '0;
            sc          <= '0;
            exp_tt      <= expected_tt;
            probe_out   <= '0;
            busy        <= 1'b1;
            truth_table <= '0;
            ones_count  <= '0;
            match       <= 1'b0;
          end
        end
        DRIVE: begin
          if (!hold_end) begin
            sc <= sc + SW'(1);
          end else begin
            sc          <= '0;
            truth_table <= tt_next;
            ones_count  <= ones_count + (N_IN+1)'(probe_in);
            if (last_vec) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
              match <= (tt_next == exp_tt);
            end else begin
              vec       <= vec + N_IN'(1);
              probe_out <= vec + N_IN'(1);
            end
          end
        end
        FINISH: begin
          state     <= IDLE;
          done      <= 1'b0;
          vec       <= '0;
          probe_out <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/blackbox_prober.md
Name: blackbox_prober

Overview:
- Sequential characterisation engine for small combinational black boxes with an N_IN-input, 1-output interface.
- It sits on the driving side of the box's interface. It sweeps every input vector, waits for settling, samples the box output and assembles the complete truth table.
- It reports the truth table, the count of ones (minterms), and a pass/fail compare against an expected table.
- It is used on-chip to verify gate-level puzzle blocks against their specified function.

Parameters:
- N_IN, 3, number of black-box inputs; sweeps 2**N_IN vectors.
- SETTLE, 2, cycles each vector is held before sampling; must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- expected_tt  in  2**N_IN  reference truth table; bit k is the required output for input vector k. Sampled on the start cycle.
- probe_out  out  N_IN  vector driven into the black box; for N_IN=3, bits {2,1,0} drive {o,h,i}.
- probe_in  in  1  black-box output (j).
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- truth_table  out  2**N_IN  captured outputs; bit k is probe_in observed under vector k.
- ones_count  out  N_IN+1  number of 1 bits in truth_table.
- match  out  1  truth_table == latched expected_tt; valid from done, held until the next start.

Behaviour:
- States: IDLE, DRIVE, FINISH. Registers: vec (N_IN bits), settle counter sc, shadow table, count, latched exp.
- Reset (synchronous, any state, including mid-sweep):
  - state=IDLE; probe_out=0; busy=0; done=0.
  - truth_table=0; ones_count=0; match=0; sc=0; vec=0.
  - A partial sweep is discarded.
- IDLE:
  - start=1 at edge t → state=DRIVE, vec=0, sc=0, exp<=expected_tt.
  - truth_table, ones_count and match are cleared at that same edge.
  - busy=1 from cycle t+1.
- DRIVE:
  - probe_out=vec, registered, so it is stable for the whole hold window.
  - Each edge with sc<SETTLE-1: sc<=sc+1.
  - Edge with sc==SETTLE-1:
    - truth_table[vec]<=probe_in; ones_count<=ones_count+probe_in; sc<=0.
    - If vec==2**N_IN-1 → FINISH. Otherwise vec<=vec+1.
  - Each vector is held exactly SETTLE cycles.
- FINISH (one cycle): done=1; busy=0; match=(truth_table==exp). Next edge → IDLE, done=0.
- Latency: start sampled at edge t → done high during cycle t+1+2**N_IN*SETTLE. For defaults, start at t → done at t+17.
- probe_out after the sweep returns to 0 on entry to IDLE.
- start while busy/DRIVE/FINISH is ignored; no restart and no queueing.
- start held high continuously: a new sweep begins on the first IDLE cycle after FINISH. Back-to-back sweeps are separated by exactly one IDLE cycle.
- Results (truth_table, ones_count, match) hold stable in IDLE until the next accepted start.
- Width rules:
  - ones_count max is 2**N_IN; it needs N_IN+1 bits and never wraps.
  - vec wrap from 2**N_IN-1 is never executed, because the state leaves DRIVE first.
- probe_in is treated as synchronous and is sampled only on the final cycle of each hold window. Values in earlier cycles are ignored, which covers glitches during settling.

Test Plan:
- Reference target j = ~o & (~i | h), defaults, expected_tt=8'h0D, start pulse at t:
  - probe_out steps 0..7, each held 2 cycles.
  - done at t+17; truth_table=8'h0D; ones_count=3; match=1.
- Same target with expected_tt=8'h0F:
  - truth_table=8'h0D; match=0; done timing unchanged.
- Constant-1 box with SETTLE=1: truth_table=8'hFF; ones_count=4'd8, no overflow; done at t+9. Constant-0 box: 8'h00; count 0.
- rst asserted at vector 4 mid-sweep:
  - Next cycle: all outputs 0, state IDLE, no done pulse.
  - A fresh start then completes normally with the correct table.
- Start pulsed again at vec=3 during a sweep: ignored; single done at t+17.
- Start held high for 40 cycles: two done pulses at t+17 and t+35.
- Results stay stable while idle between sweeps.
- Glitch box (probe_in toggles on the first hold cycle, correct on the second) with SETTLE=2: the correct table is captured.
